// File: rtl/mac_share_arbiter.sv
// Round-robin sharing of one 4-stage multiply-add unit between N_REQ requesters.
// Issued IDs are tagged in order; credits bound outstanding work since results cannot stall.
module mac_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [8*N_REQ-1:0]       req_a,
    input  logic [8*N_REQ-1:0]       req_b,
    input  logic [16*N_REQ-1:0]      req_c,
    output logic                     mac_valid,
    input  logic                     mac_ready,
    output logic [7:0]               mac_a,
    output logic [7:0]               mac_b,
    output logic [15:0]              mac_c,
    input  logic                     mac_res_valid,
    input  logic [15:0]              mac_res,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [15:0]              rsp_data,
    output logic [$clog2(DEPTH):0]   credits,
    output logic                     err_orphan
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned RW = ID_W + 16;

    logic [CW-1:0]   credits_q, credits_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] winner;
    logic            any_valid, has_credit, issue;

    logic [ID_W-1:0] tag_mem_q [DEPTH];
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0]   tag_cnt_q, tag_cnt_d;
    logic            tag_push, tag_pop, orphan;

    logic [RW-1:0]   res_mem_q [DEPTH];
    logic [PW-1:0]   res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CW-1:0]   res_cnt_q, res_cnt_d;
    logic [RW-1:0]   res_word;
    logic            res_store, res_take;

    logic            rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]   rsp_word_q, rsp_word_d;
    logic            rsp_pop, out_free;
    logic            err_q, err_d;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin : arb
        logic            found;
        logic [ID_W-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        winner = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign any_valid  = |req_valid;
    assign has_credit = (credits_q != '0);
    assign mac_valid  = any_valid && has_credit;
    assign issue      = mac_valid && mac_ready;

    always_comb begin
        req_ready = '0;
        mac_a     = '0;
        mac_b     = '0;
        mac_c     = '0;
        if (mac_valid) begin
            mac_a = req_a[8*32'(winner) +: 8];
            mac_b = req_b[8*32'(winner) +: 8];
            mac_c = req_c[16*32'(winner) +: 16];
            if (mac_ready) begin
                req_ready[winner] = 1'b1;
            end
        end
    end

    // Tag FIFO bookkeeping; a result with no tag is an orphan and is dropped.
    always_comb begin
        tag_push  = issue;
        tag_pop   = mac_res_valid && (tag_cnt_q != '0);
        orphan    = mac_res_valid && (tag_cnt_q == '0);
        tag_wr_d  = tag_wr_q + PW'(tag_push);
        tag_rd_d  = tag_rd_q + PW'(tag_pop);
        tag_cnt_d = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
        res_word  = {tag_mem_q[tag_rd_q], mac_res};
        rr_ptr_d  = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
        end
    end

    // Response register fed by the result FIFO, bypassing it when storage is empty.
    always_comb begin
        rsp_pop     = rsp_valid_q && rsp_ready;
        out_free    = !rsp_valid_q || rsp_pop;
        res_take    = out_free && (res_cnt_q != '0);
        res_store   = tag_pop && !(out_free && (res_cnt_q == '0));
        rsp_valid_d = rsp_valid_q;
        rsp_word_d  = rsp_word_q;
        if (out_free) begin
            if (res_cnt_q != '0) begin
                rsp_valid_d = 1'b1;
                rsp_word_d  = res_mem_q[res_rd_q];
            end else if (tag_pop) begin
                rsp_valid_d = 1'b1;
                rsp_word_d  = res_word;
            end else begin
                rsp_valid_d = 1'b0;
            end
        end
        res_wr_d  = res_wr_q + PW'(res_store);
        res_rd_d  = res_rd_q + PW'(res_take);
        res_cnt_d = res_cnt_q + CW'(res_store) - CW'(res_take);
        credits_d = credits_q - CW'(issue) + CW'(rsp_pop);
        err_d     = err_q || orphan;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credits_q   <= CW'(DEPTH);
            rr_ptr_q    <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            tag_cnt_q   <= '0;
            res_wr_q    <= '0;
            res_rd_q    <= '0;
            res_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            credits_q   <= credits_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            tag_cnt_q   <= tag_cnt_d;
            res_wr_q    <= res_wr_d;
            res_rd_q    <= res_rd_d;
            res_cnt_q   <= res_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_word_q  <= rsp_word_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wr_q] <= winner;
        end
        if (res_store) begin
            res_mem_q[res_wr_q] <= res_word;
        end
    end

    a_tag_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(tag_push && !tag_pop && (tag_cnt_q == CW'(DEPTH))));
    a_res_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(res_store && !res_take && (res_cnt_q == CW'(DEPTH))));

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_word_q[RW-1:16];
    assign rsp_data   = rsp_word_q[15:0];
    assign credits    = credits_q;
    assign err_orphan = err_q;

endmodule
